// File: rtl/adder_pkg.sv
// Shared widths for the registered 14-bit adder datapath.
package adder_pkg;
  localparam int ADDER_W = 14;
  localparam int SUM_W   = ADDER_W + 1;

  typedef logic [ADDER_W-1:0] operand_t;
  typedef logic [SUM_W-1:0]   sum_t;
endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full-adder cell; purely combinational.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/full_adder_14_bit.sv
// Registered 14-bit ripple-carry adder with carry-in; result appears one cycle after sampling.
module full_adder_14_bit
  import adder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDER_W-1:0] a,
  input  logic [ADDER_W-1:0] b,
  input  logic               cin,
  input  logic               in_valid,
  output logic [SUM_W-1:0]   sum,
  output logic               cout,
  output logic               out_valid
);
  logic [ADDER_W:0]   carry;
  logic [ADDER_W-1:0] s_bits;
  sum_t               raw_next;
  sum_t               sum_reg;
  logic               valid_reg;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < ADDER_W; gi++) begin : g_cell
      full_adder_1bit u_cell (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (carry[gi]),
        .s  (s_bits[gi]),
        .co (carry[gi+1])
      );
    end
  endgenerate

  assign raw_next = {carry[ADDER_W], s_bits};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg <= raw_next;
      end
    end
  end

  // Carry-out is taken from the stored top bit so it can never disagree with sum[14].
  assign sum       = sum_reg;
  assign cout      = sum_reg[SUM_W-1];
  assign out_valid = valid_reg;
endmodule

// File: tb/tb_full_adder_14_bit.sv
// Directed and random checks of the registered 14-bit adder.
module tb_full_adder_14_bit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] a;
  logic [13:0] b;
  logic        cin;
  logic        in_valid;
  logic [14:0] sum;
  logic        cout;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  logic [14:0] exp_sum;
  logic        exp_ov;

  always #5 clk = ~clk;

  full_adder_14_bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then settle before checks.
  task automatic step(input logic [13:0] ta, input logic [13:0] tb_, input logic tc,
                      input logic tv, input logic tr);
    a        = ta;
    b        = tb_;
    cin      = tc;
    in_valid = tv;
    rst_n    = tr;
    @(posedge clk);
    #1;
    $display("txn a=0x%04h b=0x%04h cin=%0d v=%0d rst_n=%0d -> sum=0x%04h cout=%0d ov=%0d",
             ta, tb_, tc, tv, tr, sum, cout, out_valid);
  endtask

  task automatic expect3(input string tag, input logic [14:0] es, input logic ec, input logic ev);
    chk({tag, "_sum"},  32'(sum),       32'(es));
    chk({tag, "_cout"}, 32'(cout),      32'(ec));
    chk({tag, "_ov"},   32'(out_valid), 32'(ev));
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
    #2;

    for (int i = 0; i < 2; i++) begin
      step(14'($urandom), 14'($urandom), 1'($urandom), 1'b1, 1'b0);
      expect3("reset", 15'h0000, 1'b0, 1'b0);
    end

    step(14'h2AAA, 14'h1555, 1'b0, 1'b1, 1'b1);
    expect3("alt_c0", 15'h3FFF, 1'b0, 1'b1);
    step(14'h2AAA, 14'h1555, 1'b1, 1'b1, 1'b1);
    expect3("alt_c1", 15'h4000, 1'b1, 1'b1);

    step(14'h3FFF, 14'h3FFF, 1'b1, 1'b1, 1'b1);
    expect3("max", 15'h7FFF, 1'b1, 1'b1);
    step(14'h0000, 14'h0000, 1'b0, 1'b1, 1'b1);
    expect3("zero", 15'h0000, 1'b0, 1'b1);

    step(14'h2AAA, 14'h1555, 1'b0, 1'b1, 1'b1);
    expect3("hold_pre", 15'h3FFF, 1'b0, 1'b1);
    step(14'h3FFF, 14'h3FFF, 1'b1, 1'b0, 1'b1);
    expect3("hold", 15'h3FFF, 1'b0, 1'b0);

    step(14'h0001, 14'h0001, 1'b1, 1'b1, 1'b0);
    expect3("rst_mid", 15'h0000, 1'b0, 1'b0);
    step(14'h0001, 14'h0001, 1'b1, 1'b0, 1'b1);
    expect3("rst_after", 15'h0000, 1'b0, 1'b0);

    step(14'h1234, 14'h0ABC, 1'b1, 1'b1, 1'b1);
    expect3("first_valid", 15'h1CF1, 1'b0, 1'b1);
    step(14'h2000, 14'h2000, 1'b0, 1'b1, 1'b1);
    expect3("b2b", 15'h4000, 1'b1, 1'b1);

    exp_sum = 15'h4000;
    exp_ov  = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [13:0] ra;
      logic [13:0] rb;
      logic        rc;
      logic        rv;
      ra = 14'($urandom);
      rb = 14'($urandom);
      rc = 1'($urandom);
      rv = 1'($urandom);
      if (rv) exp_sum = 15'(ra) + 15'(rb) + 15'(rc);
      exp_ov = rv;
      step(ra, rb, rc, rv, 1'b1);
      expect3("rand", exp_sum, exp_sum[14], exp_ov);
      chk("rand_cout_eq", 32'(cout), 32'(sum[14]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
